// File: rtl/pre_if_pc_gen_if.sv
// Next-PC selection inputs and fetch-PC outputs exchanged between PCSEL, PRE_IF and IF.
// The master drives the select code, targets and stall; the slave (PRE_IF) returns the fetch PC.
interface pre_if_pc_gen_if;
    logic [2:0]  PCSel;
    logic [31:0] ImmeJump_Target;
    logic [31:0] Branch_Target;
    logic [31:0] JR_Target;
    logic [31:0] EPC;
    logic [31:0] Except_Target;
    logic [31:0] MEM_PC;
    logic        IF_Stall;
    logic [31:0] PREIF_PC;
    logic        PREIF_Valid;
    logic        PREIF_AdEL;
    logic        PC_Redirect;
    logic        Redirect_Pending;

    modport master (
        output PCSel, ImmeJump_Target, Branch_Target, JR_Target, EPC, Except_Target, MEM_PC,
               IF_Stall,
        input  PREIF_PC, PREIF_Valid, PREIF_AdEL, PC_Redirect, Redirect_Pending
    );

    modport slave (
        input  PCSel, ImmeJump_Target, Branch_Target, JR_Target, EPC, Except_Target, MEM_PC,
               IF_Stall,
        output PREIF_PC, PREIF_Valid, PREIF_AdEL, PC_Redirect, Redirect_Pending
    );
endinterface

// File: rtl/pre_if_pc_gen.sv
// PRE_IF fetch-PC generator: selects the next PC and buffers one redirect while IF is stalled.
//   state    | meaning
//   EMPTY    | no redirect buffered
//   PEND_BR  | branch-class target buffered in pend_target
//   PEND_EXC | exception-class target buffered in pend_target (wins over any branch)
module pre_if_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input logic             clk,
    input logic             rst,
    pre_if_pc_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        PEND_BR  = 2'd1,
        PEND_EXC = 2'd2
    } pend_state_t;

    pend_state_t state, state_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic [31:0] pc, pc_nxt;
    logic        valid;
    logic        redirect, redirect_nxt;
    logic        is_exc, is_br;
    logic [31:0] sel_target;

    always_comb begin
        is_exc     = 1'b0;
        is_br      = 1'b0;
        sel_target = pc + 32'd4;
        case (bus.PCSel)
            3'b001: begin is_br  = 1'b1; sel_target = bus.ImmeJump_Target; end
            3'b010: begin is_exc = 1'b1; sel_target = bus.EPC;             end
            3'b011: begin is_exc = 1'b1; sel_target = bus.Except_Target;   end
            3'b100: begin is_br  = 1'b1; sel_target = bus.Branch_Target;   end
            3'b101: begin is_br  = 1'b1; sel_target = bus.JR_Target;       end
            3'b110: begin is_exc = 1'b1; sel_target = bus.MEM_PC;          end
            default: ;
        endcase
    end

    // The first edge after reset only raises Valid so RESET_PC itself is fetched.
    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        pc_nxt          = pc;
        redirect_nxt    = 1'b0;
        if (valid) begin
            if (bus.IF_Stall) begin
                if (is_exc) begin
                    state_nxt       = PEND_EXC;
                    pend_target_nxt = sel_target;
                end else if (is_br && state == EMPTY) begin
                    state_nxt       = PEND_BR;
                    pend_target_nxt = sel_target;
                end
            end else begin
                state_nxt = EMPTY;
                if (is_exc) begin
                    pc_nxt       = sel_target;
                    redirect_nxt = 1'b1;
                end else if (state != EMPTY) begin
                    pc_nxt       = pend_target;
                    redirect_nxt = 1'b1;
                end else if (is_br) begin
                    pc_nxt       = sel_target;
                    redirect_nxt = 1'b1;
                end else begin
                    pc_nxt = pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            pend_target <= 32'd0;
            pc          <= RESET_PC;
            valid       <= 1'b0;
            redirect    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
            pc          <= pc_nxt;
            valid       <= 1'b1;
            redirect    <= redirect_nxt;
        end
    end

    assign bus.PREIF_PC         = pc;
    assign bus.PREIF_Valid      = valid;
    assign bus.PREIF_AdEL       = |pc[1:0];
    assign bus.PC_Redirect      = redirect;
    assign bus.Redirect_Pending = (state != EMPTY);
endmodule

// File: tb/tb_pre_if_pc_gen.sv
// Self-checking bench for pre_if_pc_gen: directed scenarios with literal checks, then random
// stimulus compared every cycle against a behavioural model of the fetch-PC rules.
module tb_pre_if_pc_gen;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic clk;
    logic rst;
    pre_if_pc_gen_if bus_i ();

    pre_if_pc_gen #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: fetch PC plus at most one buffered redirect.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_redir;
    logic        m_pend;
    logic        m_pend_exc;
    logic [31:0] m_pend_tgt;
    logic        m_ready = 1'b0;

    function automatic int code_class(input logic [2:0] c);
        // 2 = exception class, 1 = branch class, 0 = sequential
        if (c == 3'b010 || c == 3'b011 || c == 3'b110) return 2;
        if (c == 3'b001 || c == 3'b100 || c == 3'b101) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] code_target(input logic [2:0] c);
        case (c)
            3'b001:  return bus_i.ImmeJump_Target;
            3'b010:  return bus_i.EPC;
            3'b011:  return bus_i.Except_Target;
            3'b100:  return bus_i.Branch_Target;
            3'b101:  return bus_i.JR_Target;
            3'b110:  return bus_i.MEM_PC;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        int          cls;
        logic [31:0] tgt;
        cls = code_class(bus_i.PCSel);
        tgt = code_target(bus_i.PCSel);
        if (rst) begin
            m_pc    = RESET_PC;
            m_valid = 1'b0;
            m_redir = 1'b0;
            m_pend  = 1'b0;
            m_ready = 1'b1;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_redir = 1'b0;
        end else if (bus_i.IF_Stall) begin
            m_redir = 1'b0;
            if (cls == 2) begin
                m_pend = 1'b1; m_pend_exc = 1'b1; m_pend_tgt = tgt;
            end else if (cls == 1 && !m_pend) begin
                m_pend = 1'b1; m_pend_exc = 1'b0; m_pend_tgt = tgt;
            end
        end else begin
            m_redir = 1'b1;
            if (cls == 2)      m_pc = tgt;
            else if (m_pend)   m_pc = m_pend_tgt;
            else if (cls == 1) m_pc = tgt;
            else begin
                m_pc    = m_pc + 32'd4;
                m_redir = 1'b0;
            end
            m_pend = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_pc",       bus_i.PREIF_PC,                  m_pc);
            chk("model_valid",    {31'd0, bus_i.PREIF_Valid},      {31'd0, m_valid});
            chk("model_adel",     {31'd0, bus_i.PREIF_AdEL},       {31'd0, |m_pc[1:0]});
            chk("model_redirect", {31'd0, bus_i.PC_Redirect},      {31'd0, m_redir});
            chk("model_pending",  {31'd0, bus_i.Redirect_Pending}, {31'd0, m_pend});
        end
    end

    // Drive one cycle: random targets, the selected one overridden by tgt; returns at next negedge.
    task automatic apply(input logic r, input logic stall, input logic [2:0] sel,
                         input logic [31:0] tgt);
        rst                   = r;
        bus_i.IF_Stall        = stall;
        bus_i.PCSel           = sel;
        bus_i.ImmeJump_Target = $urandom;
        bus_i.Branch_Target   = $urandom;
        bus_i.JR_Target       = $urandom;
        bus_i.EPC             = $urandom;
        bus_i.Except_Target   = $urandom;
        bus_i.MEM_PC          = $urandom;
        case (sel)
            3'b001: bus_i.ImmeJump_Target = tgt;
            3'b010: bus_i.EPC             = tgt;
            3'b011: bus_i.Except_Target   = tgt;
            3'b100: bus_i.Branch_Target   = tgt;
            3'b101: bus_i.JR_Target       = tgt;
            3'b110: bus_i.MEM_PC          = tgt;
            default: ;
        endcase
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus_i.IF_Stall = 1'b0;
        bus_i.PCSel    = 3'b000;
        @(negedge clk);
        apply(1'b1, 1'b0, 3'b000, 32'd0);
        chk("reset_pc",    bus_i.PREIF_PC, 32'hBFC0_0000);
        chk("reset_valid", {31'd0, bus_i.PREIF_Valid}, 32'd0);
        chk("reset_pend",  {31'd0, bus_i.Redirect_Pending}, 32'd0);

        apply(1'b0, 1'b0, 3'b000, 32'd0);
        chk("run_valid", {31'd0, bus_i.PREIF_Valid}, 32'd1);
        chk("run_pc0",   bus_i.PREIF_PC, 32'hBFC0_0000);
        apply(1'b0, 1'b0, 3'b000, 32'd0);
        chk("run_pc1",   bus_i.PREIF_PC, 32'hBFC0_0004);
        apply(1'b0, 1'b0, 3'b000, 32'd0);
        chk("run_pc2",   bus_i.PREIF_PC, 32'hBFC0_0008);
        chk("run_redir", {31'd0, bus_i.PC_Redirect}, 32'd0);

        apply(1'b0, 1'b0, 3'b100, 32'h8000_0040);
        chk("br_pc",    bus_i.PREIF_PC, 32'h8000_0040);
        chk("br_redir", {31'd0, bus_i.PC_Redirect}, 32'd1);
        apply(1'b0, 1'b0, 3'b000, 32'd0);
        chk("br_pc4",   bus_i.PREIF_PC, 32'h8000_0044);
        chk("br_redir_off", {31'd0, bus_i.PC_Redirect}, 32'd0);

        apply(1'b0, 1'b1, 3'b101, 32'h8000_1000);
        chk("stall_pend", {31'd0, bus_i.Redirect_Pending}, 32'd1);
        chk("stall_hold", bus_i.PREIF_PC, 32'h8000_0044);
        apply(1'b0, 1'b1, 3'b011, 32'hBFC0_0380);
        apply(1'b0, 1'b1, 3'b000, 32'd0);
        chk("stall_hold2", bus_i.PREIF_PC, 32'h8000_0044);
        apply(1'b0, 1'b0, 3'b000, 32'd0);
        chk("release_pc",   bus_i.PREIF_PC, 32'hBFC0_0380);
        chk("release_pend", {31'd0, bus_i.Redirect_Pending}, 32'd0);

        apply(1'b0, 1'b1, 3'b100, 32'h8000_2000);
        apply(1'b0, 1'b0, 3'b010, 32'h8000_3000);
        chk("prio_pc",   bus_i.PREIF_PC, 32'h8000_3000);
        chk("prio_pend", {31'd0, bus_i.Redirect_Pending}, 32'd0);

        apply(1'b0, 1'b0, 3'b001, 32'h8000_0002);
        chk("mis_pc",   bus_i.PREIF_PC, 32'h8000_0002);
        chk("mis_adel", {31'd0, bus_i.PREIF_AdEL}, 32'd1);
        apply(1'b0, 1'b0, 3'b111, 32'd0);
        chk("mis_pc4",  bus_i.PREIF_PC, 32'h8000_0006);
        chk("mis_adel2", {31'd0, bus_i.PREIF_AdEL}, 32'd1);

        apply(1'b0, 1'b0, 3'b001, 32'hFFFF_FFFC);
        apply(1'b0, 1'b0, 3'b000, 32'd0);
        chk("wrap_pc", bus_i.PREIF_PC, 32'h0000_0000);

        apply(1'b0, 1'b1, 3'b110, 32'h8000_5000);
        chk("abort_pend_before", {31'd0, bus_i.Redirect_Pending}, 32'd1);
        apply(1'b1, 1'b1, 3'b000, 32'd0);
        chk("abort_pc",   bus_i.PREIF_PC, 32'hBFC0_0000);
        chk("abort_pend", {31'd0, bus_i.Redirect_Pending}, 32'd0);
        apply(1'b0, 1'b0, 3'b000, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            apply(($urandom_range(199) == 0), ($urandom_range(1) == 1),
                  3'($urandom_range(7)), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pre_if_pc_gen.md
# pre_if_pc_gen

Program-counter generator for the PRE_IF stage. It consumes the 3-bit `PCSel` code from the next-PC select logic plus all candidate targets, and holds the architectural fetch PC. While IF is stalled it buffers one pending redirect, and presents the fetch PC to IF with an address-error flag. It sits directly downstream of PCSEL and upstream of the IF stage / I-cache request logic.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, PC value loaded by reset.

Ports:
- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PCSel` in 3: next-PC code. 000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR, 110 MEMPC, 111 reserved.
- `ImmeJump_Target` in 32: J/JAL target.
- `Branch_Target` in 32: resolved taken-branch target.
- `JR_Target` in 32: JR/JALR register target.
- `EPC` in 32: ERET return address.
- `Except_Target` in 32: exception entry vector.
- `MEM_PC` in 32: refetch address.
- `IF_Stall` in 1: IF cannot accept a new PC this cycle.
- `PREIF_PC` out 32: current fetch PC.
- `PREIF_Valid` out 1: `PREIF_PC` is a real fetch address.
- `PREIF_AdEL` out 1: `PREIF_PC[1:0]` != 0.
- `PC_Redirect` out 1: one-cycle pulse; PC was just loaded from a non-sequential target. IF kills its in-flight fetch.
- `Redirect_Pending` out 1: a buffered redirect is waiting.

## Operation
- Redirect classes:
  - Exception class (EXC): PCSel 010, 011, 110.
  - Branch class (BR): PCSel 001, 100, 101.
  - None: 000, and reserved 111, which is treated as 000.
- Target mux: the code selects the matching target input. PC4 = `PREIF_PC` + 4, 32-bit wrap (FFFF_FFFC -> 0000_0000).
- Pending FSM:
  - States: EMPTY, PEND_BR, PEND_EXC.
  - Holds `pend_target` (32 bits).
- When `IF_Stall`=1, the PC holds. Then:
  - EXC code in any state -> PEND_EXC, capture its target. A newer EXC overwrites an older one.
  - BR code in EMPTY -> PEND_BR, capture.
  - BR code in PEND_BR or PEND_EXC -> ignored; the buffered one is older or higher priority.
  - None -> state unchanged.
- When `IF_Stall`=0, the PC loads, by priority:
  1. New EXC code this cycle.
  2. Pending target, if state != EMPTY.
  3. New BR code.
  4. PC4.
- The FSM returns to EMPTY on any non-stall cycle.
- `PC_Redirect` is registered. It is 1 in the cycle after the PC loads from choice 1, 2 or 3.
- `PREIF_AdEL` is combinational from `PREIF_PC[1:0]`. Misaligned targets are loaded unchanged; the fault is only flagged.
- `Redirect_Pending` = (state != EMPTY).

## Timing
- Reset values:
  - `PREIF_PC`=`RESET_PC`
  - `PREIF_Valid`=0
  - `PC_Redirect`=0
  - `PREIF_AdEL`=0
  - `Redirect_Pending`=0
  - FSM=EMPTY
- First cycle after `rst` deasserts: `PREIF_Valid`=1. It stays 1 until the next reset.
- `rst` asserted mid-stall or with a pending entry: the pending entry is discarded and reset values load on that edge.
- Latency: `PCSel` and targets are sampled on edge N, and the new PC is visible after edge N. Targets need only be valid in the cycle their code is presented.
- Stall release with a pending entry: the pending target loads on the first edge where `IF_Stall`=0. The FSM reads EMPTY after that edge.
- Same edge with stall=0, pending BR, and a new EXC: the EXC target loads and the pending BR is dropped.
- `IF_Stall` held for many cycles: the PC and pending entry are stable indefinitely.

## Test plan
- Reset then free-run, `IF_Stall`=0, PCSel=000:
  - `PREIF_Valid` 0 during reset, then 1.
  - PC sequence BFC00000, BFC00004, BFC00008.
  - `PC_Redirect` stays 0.
- PCSel=100 for one cycle, `Branch_Target`=8000_0040, no stall -> next PC 80000040, `PC_Redirect` pulses 1 for one cycle, then 80000044.
- Buffered redirect under stall:
  - Hold `IF_Stall`=1 for 3 cycles.
  - Present PCSel=101, JR_Target=8000_1000 in cycle 1; `Redirect_Pending`=1.
  - Present PCSel=011, Except_Target=BFC0_0380 in cycle 2.
  - Release stall -> PC loads BFC00380 and `Redirect_Pending` returns to 0.
- Priority at release:
  - Pending BR 8000_2000.
  - Stall drops in the same cycle as PCSel=010, EPC=8000_3000.
  - Required: PC=80003000, pending cleared.
- Misalignment:
  - PCSel=001, ImmeJump_Target=8000_0002 -> `PREIF_AdEL`=1 with PC 80000002.
  - Then PC4 gives 80000006, `AdEL` still 1.
- Wrap and reset abort:
  - From PC FFFF_FFFC, PCSel=000 -> next PC 00000000.
  - With PEND_EXC held under stall, assert `rst` -> PC BFC00000, `Redirect_Pending`=0.
